// File: rtl/shared_out_arbiter_pkg.sv
// Shared types and code mapping for every writer of the shared code output.
// Other blocks that produce codes for this output import the same mapping.
package shared_out_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    LOCKED
  } arb_state_t;

  localparam int unsigned CODE_DEFAULT = 2;
  localparam int unsigned CODE_W_MAX   = 64;

  // 0 and 1 pass through unchanged; every other code collapses to CODE_DEFAULT.
  function automatic int unsigned map_code(input logic [CODE_W_MAX-1:0] code);
    if (code == '0) begin
      return 0;
    end else if (code == CODE_W_MAX'(1)) begin
      return 1;
    end else begin
      return CODE_DEFAULT;
    end
  endfunction

endpackage

// File: rtl/shared_out_arbiter_if.sv
// Requester/output bundle of the shared output arbiter.
// The master side is the requester population; the slave side is the arbiter.
interface shared_out_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 2
);
  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_code;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         binary_out;
  logic                      out_valid;
  logic [IdxW-1:0]           out_src;

  modport master (
    output req_valid,
    output req_code,
    output req_lock,
    input  req_ready,
    input  binary_out,
    input  out_valid,
    input  out_src
  );

  modport slave (
    input  req_valid,
    input  req_code,
    input  req_lock,
    output req_ready,
    output binary_out,
    output out_valid,
    output out_src
  );

endinterface

// File: rtl/shared_out_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit of valid_i after position ptr_i,
// wrapping, so the requester at ptr_i itself is examined last.
module rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IdxW-1:0]    idx_o,
  output logic               any_o
);

  logic [IdxW-1:0] pos;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      pos = IdxW'((32'(ptr_i) + k) % NUM_REQ);
      if (!any_o && valid_i[pos]) begin
        any_o        = 1'b1;
        idx_o        = pos;
        grant_o[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_out_arbiter.sv
// Sole owner of the shared code output: round-robin arbitration with bounded lock,
// one admitted transfer per cycle, mapped code registered one cycle later.
module shared_out_arbiter
  import shared_out_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned DATA_W   = 2,
  parameter int unsigned MAX_HOLD = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  shared_out_arbiter_if.slave bus
);

  localparam int unsigned IdxW  = $clog2(NUM_REQ);
  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

  arb_state_t         state_q, state_d;
  logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [DATA_W-1:0]  binary_out_q, binary_out_d;
  logic               out_valid_q;
  logic [IdxW-1:0]    out_src_q;

  logic [NUM_REQ-1:0] pick_valid;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IdxW-1:0]    pick_idx;
  logic               pick_any;

  logic [NUM_REQ-1:0] grant;
  logic [IdxW-1:0]    grant_idx;
  logic               transfer;
  logic [DATA_W-1:0]  code_sel;
  logic               owner_valid;
  logic               owner_lock;
  logic               hold_full;

  assign owner_valid = bus.req_valid[rr_ptr_q];
  assign owner_lock  = bus.req_lock[rr_ptr_q];
  assign hold_full   = (hold_cnt_q == HoldW'(MAX_HOLD));

  // Owner is removed from the search once its lock budget is spent.
  always_comb begin
    pick_valid = bus.req_valid;
    if (state_q == LOCKED && hold_full) begin
      pick_valid[rr_ptr_q] = 1'b0;
    end
  end

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .valid_i(pick_valid),
    .ptr_i  (rr_ptr_q),
    .grant_o(pick_grant),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    grant      = '0;
    grant_idx  = '0;
    unique case (state_q)
      IDLE, GRANT: begin
        if (pick_any) begin
          grant      = pick_grant;
          grant_idx  = pick_idx;
          rr_ptr_d   = pick_idx;
          state_d    = bus.req_lock[pick_idx] ? LOCKED : GRANT;
          hold_cnt_d = bus.req_lock[pick_idx] ? HoldW'(1) : '0;
        end else begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (owner_valid && !hold_full) begin
          grant[rr_ptr_q] = 1'b1;
          grant_idx       = rr_ptr_q;
          if (owner_lock) begin
            hold_cnt_d = hold_cnt_q + HoldW'(1);
          end else begin
            state_d    = GRANT;
            hold_cnt_d = '0;
          end
        end else if (pick_any) begin
          // Owner dropped out or is barred: behave as GRANT among the others.
          grant      = pick_grant;
          grant_idx  = pick_idx;
          rr_ptr_d   = pick_idx;
          state_d    = bus.req_lock[pick_idx] ? LOCKED : GRANT;
          hold_cnt_d = bus.req_lock[pick_idx] ? HoldW'(1) : '0;
        end else if (owner_valid) begin
          // Budget spent but nobody else wants the output: keep serving the owner.
          grant[rr_ptr_q] = 1'b1;
          grant_idx       = rr_ptr_q;
          state_d         = owner_lock ? LOCKED : GRANT;
          hold_cnt_d      = owner_lock ? HoldW'(1) : '0;
        end else begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = '0;
      end
    endcase
  end

  assign transfer     = |grant;
  assign code_sel     = bus.req_code[grant_idx*DATA_W +: DATA_W];
  assign binary_out_d = DATA_W'(map_code(CODE_W_MAX'(code_sel)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= IdxW'(NUM_REQ - 1);
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      binary_out_q <= '0;
      out_valid_q  <= 1'b0;
      out_src_q    <= '0;
    end else if (transfer) begin
      binary_out_q <= binary_out_d;
      out_valid_q  <= 1'b1;
      out_src_q    <= grant_idx;
    end else begin
      out_valid_q  <= 1'b0;
    end
  end

  assign bus.req_ready  = grant;
  assign bus.binary_out = binary_out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_src    = out_src_q;

endmodule
